// File: rtl/pec_sink_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pec_sink_if : valid/ready output beat stream of the PEC sink
// Revision    : 1.0
// ---------------------------------------------------------------------------
interface pec_sink_if #(
   parameter int DATA_W = 32
);
   logic              valid;
   logic              ready;
   logic              last;
   logic [DATA_W-1:0] data;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);
endinterface
`default_nettype wire

// File: rtl/pec_sink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pec_sink : captures per-pixel accumulator results and serialises them onto
//            a valid/ready beat stream, one feature per beat.
// Options  : define PEC_SNK_RELU_EN to zero negative features at the output.
// Revision : 1.0
// ---------------------------------------------------------------------------
package pec_sink_pkg;
   typedef enum logic [2:0] {
      CTRL_IDLE         = 3'd0,
      CTRL_READY        = 3'd1,
      CTRL_BUSY         = 3'd2,
      CTRL_STORE_OUTPUT = 3'd3
   } pec_ctrl_fsm_state_t;

   typedef enum logic [1:0] {
      OP_NOP     = 2'd0,
      OP_COMPUTE = 2'd1,
      OP_LOAD    = 2'd2,
      OP_CLEAR   = 2'd3
   } pec_operations_e;

   typedef enum logic [1:0] {
      SNK_READY = 2'd0,
      SNK_BUSY  = 2'd1,
      SNK_STORE = 2'd2
   } pec_snk_state_e;

   typedef struct packed {
      pec_snk_state_e curr_state;
      pec_snk_state_e next_state;
   } pec_snk_fsm_state_t;
endpackage

module pec_sink
   import pec_sink_pkg::*;
#(
   parameter int NUM_FEAT = 16,
   parameter int ACC_W    = 24,
   parameter int DATA_W   = 32,
   parameter int PIX_W    = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  pec_ctrl_fsm_state_t       ctrl_state_i,
   input  logic                      start_i,
   input  logic [1:0]                op_i,
   input  logic [PIX_W-1:0]          num_pixels_i,
   input  logic [NUM_FEAT*ACC_W-1:0] acc_i,
   output pec_snk_fsm_state_t        snk_fsm_state_o,
   pec_sink_if.master                m,
   output logic                      acc_clear_o,
   output logic [PIX_W-1:0]          pix_cnt_o
);
   localparam int               FEAT_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam logic [FEAT_W-1:0] LAST_FEAT = FEAT_W'(NUM_FEAT - 1);
   localparam logic [PIX_W-1:0]  PIX_MAX   = '1;

   pec_snk_state_e            curr_state;
   pec_snk_state_e            next_state;
   logic [FEAT_W-1:0]         feat_cnt;
   logic [PIX_W-1:0]          target;
   logic [ACC_W-1:0]          cap_buf [NUM_FEAT];

   logic                      handshake;
   logic                      last_feat;
   logic                      last_pix;
   logic                      arm;
   logic                      capture;
   logic signed [ACC_W-1:0]   cur_feat;
   logic signed [DATA_W-1:0]  cur_ext;

   assign handshake = m.valid && m.ready;
   assign last_feat = (feat_cnt == LAST_FEAT);
   // One extra bit so the compare stays correct once pix_cnt_o has saturated.
   assign last_pix  = (({1'b0, pix_cnt_o} + (PIX_W+1)'(1)) >= {1'b0, target});
   assign arm       = start_i && (op_i == OP_COMPUTE) && (curr_state == SNK_READY);
   assign capture   = (curr_state != SNK_STORE) && (ctrl_state_i == CTRL_STORE_OUTPUT);

   always_comb begin
      next_state = curr_state;
      case (curr_state)
         SNK_READY, SNK_BUSY: if (capture) next_state = SNK_STORE;
         SNK_STORE: begin
            if (handshake && last_feat)
               next_state = last_pix ? SNK_READY : SNK_BUSY;
         end
         default: next_state = SNK_READY;
      endcase
   end

   assign snk_fsm_state_o.curr_state = curr_state;
   assign snk_fsm_state_o.next_state = next_state;

   assign cur_feat = cap_buf[feat_cnt];
   assign cur_ext  = DATA_W'(cur_feat);

   assign m.valid = (curr_state == SNK_STORE);
   assign m.last  = m.valid && last_feat && last_pix;
`ifdef PEC_SNK_RELU_EN
   assign m.data  = cur_feat[ACC_W-1] ? '0 : cur_ext;
`else
   assign m.data  = cur_ext;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         curr_state  <= SNK_READY;
         feat_cnt    <= '0;
         target      <= PIX_W'(1);
         pix_cnt_o   <= '0;
         acc_clear_o <= 1'b0;
         for (int f = 0; f < NUM_FEAT; f++) cap_buf[f] <= '0;
      end else begin
         curr_state  <= next_state;
         acc_clear_o <= capture;
         if (arm) begin
            target    <= (num_pixels_i == '0) ? PIX_W'(1) : num_pixels_i;
            pix_cnt_o <= '0;
         end
         // capture only happens outside SNK_STORE, handshake only inside it
         if (capture) begin
            for (int f = 0; f < NUM_FEAT; f++) cap_buf[f] <= acc_i[f*ACC_W +: ACC_W];
            feat_cnt <= '0;
         end else if (handshake) begin
            feat_cnt <= last_feat ? '0 : feat_cnt + FEAT_W'(1);
            if (last_feat && (pix_cnt_o != PIX_MAX))
               pix_cnt_o <= pix_cnt_o + PIX_W'(1);
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pec_sink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pec_sink : directed self-checking bench for pec_sink
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_pec_sink;
   import pec_sink_pkg::*;

   localparam int NUM_FEAT = 16;
   localparam int ACC_W    = 24;
   localparam int DATA_W   = 32;
   localparam int PIX_W    = 16;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   pec_ctrl_fsm_state_t       ctrl_state = CTRL_IDLE;
   logic                      start = 1'b0;
   logic [1:0]                op = 2'd0;
   logic [PIX_W-1:0]          num_pixels = '0;
   logic [NUM_FEAT*ACC_W-1:0] acc = '0;
   pec_snk_fsm_state_t        snk_state;
   logic                      acc_clear;
   logic [PIX_W-1:0]          pix_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   pec_sink_if #(.DATA_W(DATA_W)) mif ();

   pec_sink #(
      .NUM_FEAT(NUM_FEAT), .ACC_W(ACC_W), .DATA_W(DATA_W), .PIX_W(PIX_W)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ctrl_state_i   (ctrl_state),
      .start_i        (start),
      .op_i           (op),
      .num_pixels_i   (num_pixels),
      .acc_i          (acc),
      .snk_fsm_state_o(snk_state),
      .m              (mif),
      .acc_clear_o    (acc_clear),
      .pix_cnt_o      (pix_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finished");
      $fatal(1);
   end

   // Expected beat for a signed accumulator value.
   function automatic logic [DATA_W-1:0] exp_beat(input int v);
`ifdef PEC_SNK_RELU_EN
      return (v < 0) ? '0 : DATA_W'(v);
`else
      return DATA_W'(v);
`endif
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_acc_ramp(input int base, input int step);
      for (int f = 0; f < NUM_FEAT; f++) acc[f*ACC_W +: ACC_W] = ACC_W'(base + f*step);
   endtask

   // Present CTRL_STORE_OUTPUT for one edge; returns with beat 0 on the bus.
   task automatic kick(input logic do_arm, input logic [PIX_W-1:0] n);
      start      = do_arm;
      op         = OP_COMPUTE;
      num_pixels = n;
      ctrl_state = CTRL_STORE_OUTPUT;
      cyc();
      start      = 1'b0;
      ctrl_state = CTRL_BUSY;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ctrl_state = CTRL_IDLE;
      mif.ready = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
      ctrl_state = CTRL_READY;
      #1;
      n_checks++; if (snk_state.curr_state !== SNK_READY) $display("FAIL reset_curr got %0d exp %0d", snk_state.curr_state, SNK_READY); else n_pass++;
      n_checks++; if (snk_state.next_state !== SNK_READY) $display("FAIL reset_next got %0d exp %0d", snk_state.next_state, SNK_READY); else n_pass++;
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", mif.valid); else n_pass++;
      n_checks++; if (mif.last !== 1'b0) $display("FAIL reset_last got %b exp 0", mif.last); else n_pass++;
      n_checks++; if (mif.data !== 32'h0) $display("FAIL reset_data got %h exp 0", mif.data); else n_pass++;
      n_checks++; if (acc_clear !== 1'b0) $display("FAIL reset_acc_clear got %b exp 0", acc_clear); else n_pass++;
      n_checks++; if (pix_cnt !== 16'd0) $display("FAIL reset_pix_cnt got %0d exp 0", pix_cnt); else n_pass++;
      cyc();
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL idle_valid got %b exp 0", mif.valid); else n_pass++;
   endtask

   task automatic test_single_pixel();
      pec_snk_state_e exp_next;
      set_acc_ramp(-8, 1);
      mif.ready = 1'b1;
      kick(1'b1, 16'd1);
      set_acc_ramp(1000, 3);
      for (int b = 0; b < NUM_FEAT; b++) begin
         #1;
         exp_next = (b == 15) ? SNK_READY : SNK_STORE;
         n_checks++; if (mif.valid !== 1'b1) $display("FAIL single_valid b=%0d got %b exp 1", b, mif.valid); else n_pass++;
         n_checks++; if (mif.data !== exp_beat(b - 8)) $display("FAIL single_data b=%0d got %h exp %h", b, mif.data, exp_beat(b - 8)); else n_pass++;
         n_checks++; if (mif.last !== (b == 15)) $display("FAIL single_last b=%0d got %b exp %b", b, mif.last, (b == 15)); else n_pass++;
         n_checks++; if (snk_state.next_state !== exp_next) $display("FAIL single_next b=%0d got %0d exp %0d", b, snk_state.next_state, exp_next); else n_pass++;
         n_checks++; if (acc_clear !== (b == 0)) $display("FAIL single_acc_clear b=%0d got %b exp %b", b, acc_clear, (b == 0)); else n_pass++;
         cyc();
      end
      #1;
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL single_end_valid got %b exp 0", mif.valid); else n_pass++;
      n_checks++; if (snk_state.curr_state !== SNK_READY) $display("FAIL single_end_state got %0d exp %0d", snk_state.curr_state, SNK_READY); else n_pass++;
      n_checks++; if (pix_cnt !== 16'd1) $display("FAIL single_end_pix got %0d exp 1", pix_cnt); else n_pass++;
   endtask

   task automatic test_multi_pixel();
      pec_snk_state_e exp_st;
      set_acc_ramp(-8, 1);
      mif.ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         kick(p == 0, 16'd3);
         for (int b = 0; b < NUM_FEAT; b++) begin
            #1;
            n_checks++; if (mif.data !== exp_beat(b - 8)) $display("FAIL multi_data p=%0d b=%0d got %h exp %h", p, b, mif.data, exp_beat(b - 8)); else n_pass++;
            n_checks++; if (mif.last !== (p == 2 && b == 15)) $display("FAIL multi_last p=%0d b=%0d got %b exp %b", p, b, mif.last, (p == 2 && b == 15)); else n_pass++;
            if (b == 15) begin
               exp_st = (p < 2) ? SNK_BUSY : SNK_READY;
               n_checks++; if (snk_state.next_state !== exp_st) $display("FAIL multi_next p=%0d got %0d exp %0d", p, snk_state.next_state, exp_st); else n_pass++;
            end
            cyc();
         end
         #1;
         exp_st = (p < 2) ? SNK_BUSY : SNK_READY;
         n_checks++; if (pix_cnt !== PIX_W'(p + 1)) $display("FAIL multi_pix p=%0d got %0d exp %0d", p, pix_cnt, p + 1); else n_pass++;
         n_checks++; if (snk_state.curr_state !== exp_st) $display("FAIL multi_state p=%0d got %0d exp %0d", p, snk_state.curr_state, exp_st); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int hs = 0;
      int hold = 0;
      int cycles = 0;
      logic tog = 1'b1;
      logic stalled = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      logic prev_last = 1'b0;
      set_acc_ramp(-7000, 1000);
      mif.ready = 1'b1;
      kick(1'b1, 16'd1);
      while (hs < NUM_FEAT && cycles < 200) begin
         if (hs == 7 && hold < 5) begin
            mif.ready = 1'b0;
            hold++;
         end else begin
            mif.ready = tog;
            tog = ~tog;
         end
         #1;
         if (stalled) begin
            n_checks++; if (mif.data !== prev_data) $display("FAIL bp_stable_data hs=%0d got %h exp %h", hs, mif.data, prev_data); else n_pass++;
            n_checks++; if (mif.last !== prev_last) $display("FAIL bp_stable_last hs=%0d got %b exp %b", hs, mif.last, prev_last); else n_pass++;
         end
         n_checks++; if (mif.valid !== 1'b1) $display("FAIL bp_valid hs=%0d got %b exp 1", hs, mif.valid); else n_pass++;
         n_checks++; if (mif.data !== exp_beat(-7000 + 1000*hs)) $display("FAIL bp_data hs=%0d got %h exp %h", hs, mif.data, exp_beat(-7000 + 1000*hs)); else n_pass++;
         n_checks++; if (mif.last !== (hs == 15)) $display("FAIL bp_last hs=%0d got %b exp %b", hs, mif.last, (hs == 15)); else n_pass++;
         stalled   = !mif.ready;
         prev_data = mif.data;
         prev_last = mif.last;
         if (mif.valid && mif.ready) hs++;
         cycles++;
         cyc();
      end
      mif.ready = 1'b1;
      #1;
      n_checks++; if (hs != NUM_FEAT) $display("FAIL bp_handshakes got %0d exp %0d", hs, NUM_FEAT); else n_pass++;
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL bp_end_valid got %b exp 0", mif.valid); else n_pass++;
      n_checks++; if (pix_cnt !== 16'd1) $display("FAIL bp_end_pix got %0d exp 1", pix_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid_stream();
      set_acc_ramp(50, -9);
      mif.ready = 1'b1;
      kick(1'b1, 16'd1);
      for (int b = 0; b < 5; b++) begin
         #1;
         n_checks++; if (mif.data !== exp_beat(50 - 9*b)) $display("FAIL midrst_pre_data b=%0d got %h exp %h", b, mif.data, exp_beat(50 - 9*b)); else n_pass++;
         cyc();
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", mif.valid); else n_pass++;
      n_checks++; if (snk_state.curr_state !== SNK_READY) $display("FAIL midrst_state got %0d exp %0d", snk_state.curr_state, SNK_READY); else n_pass++;
      n_checks++; if (pix_cnt !== 16'd0) $display("FAIL midrst_pix got %0d exp 0", pix_cnt); else n_pass++;
      kick(1'b1, 16'd1);
      for (int b = 0; b < NUM_FEAT; b++) begin
         #1;
         n_checks++; if (mif.data !== exp_beat(50 - 9*b)) $display("FAIL midrst_data b=%0d got %h exp %h", b, mif.data, exp_beat(50 - 9*b)); else n_pass++;
         n_checks++; if (mif.last !== (b == 15)) $display("FAIL midrst_last b=%0d got %b exp %b", b, mif.last, (b == 15)); else n_pass++;
         cyc();
      end
      #1;
      n_checks++; if (mif.valid !== 1'b0) $display("FAIL midrst_end_valid got %b exp 0", mif.valid); else n_pass++;
   endtask

   task automatic test_relu_zero_pixels();
      logic [DATA_W-1:0] exp4 [4];
      logic [DATA_W-1:0] e;
`ifdef PEC_SNK_RELU_EN
      exp4[0] = 32'h0000_0000; exp4[1] = 32'h0000_0003; exp4[2] = 32'h0000_0000; exp4[3] = 32'h0000_0000;
`else
      exp4[0] = 32'hFFFF_FFFB; exp4[1] = 32'h0000_0003; exp4[2] = 32'hFFFF_FFFF; exp4[3] = 32'h0000_0000;
`endif
      acc[0*ACC_W +: ACC_W] = -24'sd5;
      acc[1*ACC_W +: ACC_W] = 24'sd3;
      acc[2*ACC_W +: ACC_W] = -24'sd1;
      acc[3*ACC_W +: ACC_W] = 24'sd0;
      for (int f = 4; f < NUM_FEAT; f++) acc[f*ACC_W +: ACC_W] = ACC_W'((f % 2 == 1) ? -f : f);
      mif.ready = 1'b1;
      kick(1'b1, 16'd0);
      for (int b = 0; b < NUM_FEAT; b++) begin
         #1;
         e = (b < 4) ? exp4[b] : exp_beat((b % 2 == 1) ? -b : b);
         n_checks++; if (mif.data !== e) $display("FAIL relu_data b=%0d got %h exp %h", b, mif.data, e); else n_pass++;
         n_checks++; if (mif.last !== (b == 15)) $display("FAIL zero_pix_last b=%0d got %b exp %b", b, mif.last, (b == 15)); else n_pass++;
         cyc();
      end
      #1;
      n_checks++; if (snk_state.curr_state !== SNK_READY) $display("FAIL zero_pix_state got %0d exp %0d", snk_state.curr_state, SNK_READY); else n_pass++;
   endtask

   task automatic test_unarmed();
      set_acc_ramp(-8, 1);
      mif.ready = 1'b1;
      kick(1'b0, 16'd5);
      for (int b = 0; b < NUM_FEAT; b++) begin
         // a start request during emission must be ignored
         if (b == 3) begin start = 1'b1; op = OP_COMPUTE; num_pixels = 16'd5; end
         else start = 1'b0;
         #1;
         n_checks++; if (mif.last !== (b == 15)) $display("FAIL unarmed_last b=%0d got %b exp %b", b, mif.last, (b == 15)); else n_pass++;
         cyc();
      end
      start = 1'b0;
      #1;
      n_checks++; if (snk_state.curr_state !== SNK_READY) $display("FAIL unarmed_state got %0d exp %0d", snk_state.curr_state, SNK_READY); else n_pass++;
      n_checks++; if (pix_cnt !== 16'd2) $display("FAIL unarmed_pix got %0d exp 2", pix_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_multi_pixel();
      test_backpressure();
      test_reset_mid_stream();
      test_relu_zero_pixels();
      test_unarmed();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
